hash_word_writer: RTL

- Drains a completed 256-bit hash vector back out as HASH_LENGTH sequential 32-bit word writes, each with its word address.
- It is the opposite direction of the word-collecting hash receiver, which builds the 256-bit vector from (hash_address, hash_data) words.
- Uses the same address-to-bit mapping: word k = hash_vector[32k+31:32k].
- Sits between the SHA-256 core output and the digest memory/bus, with a simple valid/ready write handshake.

---
 rtl/hash_word_writer.sv | 108 ++++++++++
 1 files changed

// File: rtl/hash_word_writer.sv
`default_nettype none
// ============================================================================
//  Module   : hash_word_writer
//  Purpose  : Emits a captured 256-bit digest as sequential 32-bit word
//             writes (address k carries bits [32k+31:32k]) over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module hash_word_writer #(
  parameter int HASH_LENGTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [HASH_LENGTH*32-1:0]      hash_vector,
  input  logic                           write_ready,
  output logic                           hash_write,
  output logic [$clog2(HASH_LENGTH)-1:0] hash_address,
  output logic [31:0]                    hash_data,
  output logic                           busy,
  output logic                           hash_write_complete
);

  localparam int              c_AW    = $clog2(HASH_LENGTH);
  localparam int              c_VW    = HASH_LENGTH * 32;
  localparam logic [c_AW-1:0] c_LAST  = c_AW'(HASH_LENGTH - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WRITE = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic [c_VW-1:0] r_shadow;
  logic [c_VW-1:0] w_shadow_next;
  logic [c_AW-1:0] w_index_next;
  logic [31:0]     w_data_next;
  logic            w_write_next;
  logic            w_complete_next;
  logic            w_transfer;

  assign w_transfer = hash_write && write_ready;

  // State register; every output is registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state             <= c_IDLE;
      r_shadow            <= '0;
      hash_write          <= 1'b0;
      hash_address        <= '0;
      hash_data           <= '0;
      busy                <= 1'b0;
      hash_write_complete <= 1'b0;
    end else begin
      r_state             <= w_state_next;
      r_shadow            <= w_shadow_next;
      hash_write          <= w_write_next;
      hash_address        <= w_index_next;
      hash_data           <= w_data_next;
      busy                <= w_write_next;
      hash_write_complete <= w_complete_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (enable) w_state_next = c_WRITE;
      end
      c_WRITE: begin
        if (!enable)
          w_state_next = c_IDLE;
        else if (w_transfer && (hash_address == c_LAST))
          w_state_next = c_DONE;
      end
      c_DONE: begin
        if (!enable) w_state_next = c_IDLE;
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  // Output logic: computes the values the output registers take next cycle.
  // The word mux reads the next shadow so the first word is valid on WRITE entry.
  always_comb begin
    w_shadow_next = r_shadow;
    if ((r_state == c_IDLE) && enable)
      w_shadow_next = hash_vector;

    w_index_next = '0;
    if ((w_state_next == c_WRITE) && (r_state == c_WRITE))
      w_index_next = w_transfer ? (hash_address + c_AW'(1)) : hash_address;

    w_data_next = '0;
    if (w_state_next == c_WRITE) begin
      for (int k = 0; k < HASH_LENGTH; k++) begin
        if (w_index_next == c_AW'(k))
          w_data_next = w_shadow_next[k*32 +: 32];
      end
    end

    w_write_next    = (w_state_next == c_WRITE);
    w_complete_next = (w_state_next == c_DONE);
  end

endmodule
`default_nettype wire
